// File: rtl/dma_sched_if.sv
// Write-command channel from the DMA scheduler to the TLP transmitter.
interface dma_sched_if;
  logic        cmdValid_out;
  logic        cmdReady_in;
  logic [31:0] cmdAddr_out;
  logic [9:0]  cmdQwCount_out;
  logic        cmdIsMetric_out;
  logic [63:0] cmdMetric_out;

  modport master (
    output cmdValid_out, cmdAddr_out, cmdQwCount_out, cmdIsMetric_out, cmdMetric_out,
    input  cmdReady_in
  );

  modport slave (
    input  cmdValid_out, cmdAddr_out, cmdQwCount_out, cmdIsMetric_out, cmdMetric_out,
    output cmdReady_in
  );
endinterface

// File: rtl/dma_sched.sv
// DMA write scheduler: interleaves F2C ring data TLPs with metric updates on one command channel.
// Optional stall counter is built when DMA_SCHED_STALLCNT_EN is defined.
module dma_sched #(
  parameter int TLP_SIZE_NBITS   = 7,
  parameter int CHUNK_SIZE_NBITS = 12,
  parameter int NUM_CHUNKS_NBITS = 2
) (
  input  logic                        clk_in,
  input  logic                        rstn,
  input  logic                        dmaEnable_in,
  input  logic [31:0]                 f2cBase_in,
  input  logic [31:0]                 mtrBase_in,
  input  logic [NUM_CHUNKS_NBITS-1:0] f2cRdPtr_in,
  input  logic [31:0]                 c2fRdPtr_in,
  input  logic                        srcReady_in,
  dma_sched_if.master                 cmd,
  output logic [NUM_CHUNKS_NBITS-1:0] f2cWrPtr_out,
  output logic [31:0]                 stallCount_out
);

  localparam int TLP_IDX_NBITS = CHUNK_SIZE_NBITS - TLP_SIZE_NBITS;
  localparam int CHUNK_SHIFT   = CHUNK_SIZE_NBITS - 3;
  localparam int TLP_SHIFT     = TLP_SIZE_NBITS - 3;
  localparam logic [9:0] TLP_QWS = 10'(2 ** TLP_SHIFT);
  localparam logic [TLP_IDX_NBITS-1:0] LAST_TLP = {TLP_IDX_NBITS{1'b1}};
  localparam logic [TLP_IDX_NBITS-1:0] TLP_ZERO = {TLP_IDX_NBITS{1'b0}};
  localparam logic [TLP_IDX_NBITS-1:0] TLP_ONE  = TLP_IDX_NBITS'(1'b1);
  localparam logic [NUM_CHUNKS_NBITS-1:0] PTR_ZERO = {NUM_CHUNKS_NBITS{1'b0}};
  localparam logic [NUM_CHUNKS_NBITS-1:0] PTR_ONE  = NUM_CHUNKS_NBITS'(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    DATA   = 2'd2,
    METRIC = 2'd3
  } state_t;

  logic [1:0]                  rst_sync_r;
  state_t                      state_r, state_s;
  logic [NUM_CHUNKS_NBITS-1:0] wr_ptr_r, wr_ptr_s, wr_ptr_inc_s;
  logic [TLP_IDX_NBITS-1:0]    tlp_idx_r, tlp_idx_s;
  logic                        pending_r, pending_s;
  logic [31:0]                 last_c2f_r, last_c2f_s;
  logic                        cmd_valid_r, cmd_valid_s;
  logic                        cmd_is_metric_r, cmd_is_metric_s;
  logic [31:0]                 cmd_addr_r, cmd_addr_s;
  logic [9:0]                  cmd_qw_r, cmd_qw_s;
  logic [63:0]                 cmd_metric_r, cmd_metric_s;
  logic                        full_s, data_ok_s, c2f_changed_s, idle_next_s;
  logic [31:0]                 data_addr_s;

  // Ring fullness only matters when a new chunk is about to be started.
  assign wr_ptr_inc_s  = wr_ptr_r + PTR_ONE;
  assign full_s        = (wr_ptr_inc_s == f2cRdPtr_in);
  assign data_ok_s     = ((tlp_idx_r != TLP_ZERO) || !full_s) && srcReady_in;
  assign c2f_changed_s = (c2fRdPtr_in != last_c2f_r);
  assign data_addr_s   = f2cBase_in + (32'(wr_ptr_r) << CHUNK_SHIFT) + (32'(tlp_idx_r) << TLP_SHIFT);
  assign idle_next_s   = (state_s == IDLE);

  // Reset release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Next-state and next-command computation.
  always_comb begin
    state_s         = state_r;
    wr_ptr_s        = wr_ptr_r;
    tlp_idx_s       = tlp_idx_r;
    pending_s       = pending_r;
    last_c2f_s      = last_c2f_r;
    cmd_valid_s     = cmd_valid_r;
    cmd_is_metric_s = cmd_is_metric_r;
    cmd_addr_s      = cmd_addr_r;
    cmd_qw_s        = cmd_qw_r;
    cmd_metric_s    = cmd_metric_r;
    if (!rst_sync_r[1]) begin
      state_s         = IDLE;
      cmd_valid_s     = 1'b0;
      cmd_is_metric_s = 1'b0;
      cmd_addr_s      = 32'd0;
      cmd_qw_s        = 10'd0;
      cmd_metric_s    = 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cmd_valid_s = 1'b0;
          if (dmaEnable_in) begin
            state_s   = ARB;
            pending_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        ARB: begin
          pending_s = pending_r | c2f_changed_s;
          if (!dmaEnable_in) begin
            state_s = IDLE;
          end else if (pending_r) begin
            state_s         = METRIC;
            cmd_valid_s     = 1'b1;
            cmd_is_metric_s = 1'b1;
            cmd_addr_s      = mtrBase_in;
            cmd_qw_s        = 10'd1;
            cmd_metric_s    = {c2fRdPtr_in, 32'(wr_ptr_r)};
          end else if (data_ok_s) begin
            state_s         = DATA;
            cmd_valid_s     = 1'b1;
            cmd_is_metric_s = 1'b0;
            cmd_addr_s      = data_addr_s;
            cmd_qw_s        = TLP_QWS;
          end else begin
            state_s = ARB;
          end
        end
        DATA: begin
          pending_s = pending_r | c2f_changed_s;
          if (cmd.cmdReady_in) begin
            cmd_valid_s = 1'b0;
            state_s     = dmaEnable_in ? ARB : IDLE;
            if (tlp_idx_r == LAST_TLP) begin
              tlp_idx_s = TLP_ZERO;
              wr_ptr_s  = wr_ptr_inc_s;
              pending_s = 1'b1;
            end else begin
              tlp_idx_s = tlp_idx_r + TLP_ONE;
            end
          end else begin
            state_s = DATA;
          end
        end
        METRIC: begin
          // A pointer move while the metric was waiting re-arms the next update.
          if (cmd.cmdReady_in) begin
            cmd_valid_s = 1'b0;
            state_s     = dmaEnable_in ? ARB : IDLE;
            last_c2f_s  = cmd_metric_r[63:32];
            pending_s   = (c2fRdPtr_in != cmd_metric_r[63:32]);
          end else begin
            state_s = METRIC;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and command registers; scheduler bookkeeping is cleared on any entry to IDLE.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_r         <= IDLE;
      wr_ptr_r        <= PTR_ZERO;
      tlp_idx_r       <= TLP_ZERO;
      pending_r       <= 1'b0;
      last_c2f_r      <= 32'd0;
      cmd_valid_r     <= 1'b0;
      cmd_is_metric_r <= 1'b0;
      cmd_addr_r      <= 32'd0;
      cmd_qw_r        <= 10'd0;
      cmd_metric_r    <= 64'd0;
    end else begin
      state_r         <= state_s;
      wr_ptr_r        <= idle_next_s ? PTR_ZERO : wr_ptr_s;
      tlp_idx_r       <= idle_next_s ? TLP_ZERO : tlp_idx_s;
      pending_r       <= idle_next_s ? 1'b0 : pending_s;
      last_c2f_r      <= idle_next_s ? 32'd0 : last_c2f_s;
      cmd_valid_r     <= cmd_valid_s;
      cmd_is_metric_r <= cmd_is_metric_s;
      cmd_addr_r      <= cmd_addr_s;
      cmd_qw_r        <= cmd_qw_s;
      cmd_metric_r    <= cmd_metric_s;
    end
  end

`ifdef DMA_SCHED_STALLCNT_EN
  logic [31:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = (state_r == ARB) && dmaEnable_in && !pending_r && !data_ok_s;

  // Saturating count of arbitration cycles that found nothing to issue.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_r <= 32'd0;
    end else if (idle_next_s) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stallCount_out = stall_cnt_r;
`else
  assign stallCount_out = 32'd0;
`endif

  assign cmd.cmdValid_out    = cmd_valid_r;
  assign cmd.cmdIsMetric_out = cmd_is_metric_r;
  assign cmd.cmdAddr_out     = cmd_addr_r;
  assign cmd.cmdQwCount_out  = cmd_qw_r;
  assign cmd.cmdMetric_out   = cmd_metric_r;
  assign f2cWrPtr_out        = wr_ptr_r;

endmodule

// File: tb/tb_dma_sched.sv
// Bench for dma_sched: a table of ring configurations plus hand-written backpressure,
// disable and reset sequences, with every accepted command checked against an expected queue.
module tb_dma_sched;

  typedef struct {
    logic        is_metric;
    logic [31:0] addr;
    logic [9:0]  qw;
    logic [63:0] metric;
  } cmd_t;

  typedef struct {
    logic [31:0] f2c_base;
    logic [31:0] mtr_base;
    logic [31:0] c2f;
    logic [1:0]  rd;
    int          chunks;
    logic [1:0]  wr;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rstn;
  logic        en;
  logic [31:0] f2c_base;
  logic [31:0] mtr_base;
  logic [1:0]  rd_ptr;
  logic [31:0] c2f;
  logic        src;
  logic [1:0]  wr_ptr;
  logic [31:0] stall_cnt;
  logic [31:0] exp_stall;

  int   checks   = 0;
  int   failures = 0;
  cmd_t exp_q[$];
  vec_t vecs[4];

  dma_sched_if cmd_if();

  dma_sched dut (
    .clk_in         (clk_in),
    .rstn           (rstn),
    .dmaEnable_in   (en),
    .f2cBase_in     (f2c_base),
    .mtrBase_in     (mtr_base),
    .f2cRdPtr_in    (rd_ptr),
    .c2fRdPtr_in    (c2f),
    .srcReady_in    (src),
    .cmd            (cmd_if),
    .f2cWrPtr_out   (wr_ptr),
    .stallCount_out (stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic m, input logic [31:0] a, input logic [63:0] p);
    cmd_t c;
    c.is_metric = m;
    c.addr      = a;
    c.qw        = m ? 10'd1 : 10'd16;
    c.metric    = p;
    return c;
  endfunction

  task automatic push_chunk(input logic [31:0] base, input int k, input logic [31:0] c2f_v,
                            input logic [31:0] mtr);
    for (int t = 0; t < 32; t++) exp_q.push_back(mk(1'b0, base + 32'(k * 512 + t * 16), 64'd0));
    exp_q.push_back(mk(1'b1, mtr, {c2f_v, 32'((k + 1) % 4)}));
  endtask

  task automatic sb_check();
    cmd_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_cmd: got metric=%b addr=%h, want no command",
               cmd_if.cmdIsMetric_out, cmd_if.cmdAddr_out);
    end else begin
      e = exp_q.pop_front();
      if (cmd_if.cmdIsMetric_out !== e.is_metric || cmd_if.cmdAddr_out !== e.addr ||
          cmd_if.cmdQwCount_out !== e.qw || (e.is_metric && cmd_if.cmdMetric_out !== e.metric)) begin
        failures++;
        $display("FAIL cmd: got m=%b addr=%h qw=%0d pay=%h, want m=%b addr=%h qw=%0d pay=%h",
                 cmd_if.cmdIsMetric_out, cmd_if.cmdAddr_out, cmd_if.cmdQwCount_out,
                 cmd_if.cmdMetric_out, e.is_metric, e.addr, e.qw, e.metric);
      end
    end
  endtask

  // One clock: handshake observed on the falling edge, inputs change 1 unit after the rising edge.
  task automatic tick();
    @(negedge clk_in);
    if (rstn && cmd_if.cmdValid_out && cmd_if.cmdReady_in) sb_check();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && exp_q.size() > 0; n++) tick();
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 100 && !cmd_if.cmdValid_out; n++) tick();
    chk(name, 64'(cmd_if.cmdValid_out), 64'd1);
  endtask

  task automatic accept_one(input string name);
    wait_valid(name);
    cmd_if.cmdReady_in = 1'b1;
    tick();
    cmd_if.cmdReady_in = 1'b0;
  endtask

  task automatic do_reset(input logic en_after);
    rstn = 1'b0;
    en = 1'b0;
    cmd_if.cmdReady_in = 1'b1;
    exp_q.delete();
    @(posedge clk_in);
    #1;
    chk("reset_outputs", 64'({cmd_if.cmdValid_out, cmd_if.cmdIsMetric_out, |cmd_if.cmdQwCount_out,
                              |cmd_if.cmdAddr_out, |cmd_if.cmdMetric_out, |wr_ptr, |stall_cnt}), 64'd0);
    en = en_after;
    rstn = 1'b1;
    tick();
    tick();
    chk("release_sync", 64'(cmd_if.cmdValid_out), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 32'h0000_0ABC, 32'h0000_DEAD, 2'd1, 0, 2'd0};
    vecs[1] = '{32'hFFFF_FF00, 32'h0000_1234, 32'h0000_0007, 2'd2, 1, 2'd1};
    vecs[2] = '{32'h0001_0000, 32'h0000_0040, 32'h1234_5678, 2'd3, 2, 2'd2};
    vecs[3] = '{32'h0000_0000, 32'h0000_0200, 32'h0000_0000, 2'd0, 3, 2'd3};
`ifdef DMA_SCHED_STALLCNT_EN
    exp_stall = 32'd20;
`else
    exp_stall = 32'd0;
`endif
    rstn = 1'b0;
    en = 1'b0;
    src = 1'b1;
    c2f = 32'd0;
    rd_ptr = 2'd0;
    f2c_base = 32'd0;
    mtr_base = 32'd0;
    cmd_if.cmdReady_in = 1'b1;

    // Free-running streams until the ring fills.
    for (int i = 0; i < 4; i++) begin
      f2c_base = vecs[i].f2c_base;
      mtr_base = vecs[i].mtr_base;
      c2f      = vecs[i].c2f;
      rd_ptr   = vecs[i].rd;
      do_reset(1'b1);
      exp_q.push_back(mk(1'b1, mtr_base, {c2f, 32'd0}));
      for (int k = 0; k < vecs[i].chunks; k++) push_chunk(f2c_base, k, c2f, mtr_base);
      drain(3000);
      repeat (20) tick();
      chk($sformatf("vec%0d_wrptr", i), 64'(wr_ptr), 64'(vecs[i].wr));
      chk($sformatf("vec%0d_stalled", i), 64'(cmd_if.cmdValid_out), 64'd0);
    end

    // Host frees one chunk: chunk 3 goes out, write pointer wraps, ring full again.
    rd_ptr = 2'd1;
    push_chunk(f2c_base, 3, c2f, mtr_base);
    drain(1000);
    repeat (20) tick();
    chk("wrap_wrptr", 64'(wr_ptr), 64'd0);
    rd_ptr = 2'd2;
    push_chunk(f2c_base, 0, c2f, mtr_base);
    drain(1000);
    repeat (10) tick();
    chk("after_wrap_wrptr", 64'(wr_ptr), 64'd1);

    // Backpressure mid-DATA while the C2F pointer moves.
    f2c_base = 32'h0000_8000;
    mtr_base = 32'h0000_0300;
    c2f = 32'd0;
    rd_ptr = 2'd0;
    do_reset(1'b1);
    cmd_if.cmdReady_in = 1'b0;
    exp_q.push_back(mk(1'b1, mtr_base, 64'd0));
    accept_one("b_metric0");
    exp_q.push_back(mk(1'b0, f2c_base, 64'd0));
    accept_one("b_data0");
    exp_q.push_back(mk(1'b0, f2c_base + 32'd16, 64'd0));
    wait_valid("b_data16");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) c2f = 32'd5;
      tick();
      chk("b_hold", 64'({cmd_if.cmdValid_out, cmd_if.cmdIsMetric_out, cmd_if.cmdQwCount_out, cmd_if.cmdAddr_out}),
          64'({1'b1, 1'b0, 10'd16, f2c_base + 32'd16}));
    end
    exp_q.push_back(mk(1'b1, mtr_base, 64'h0000_0005_0000_0000));
    accept_one("b_data16_acc");
    accept_one("b_metric5");
    exp_q.push_back(mk(1'b0, f2c_base + 32'd32, 64'd0));
    accept_one("b_data32");

    // Disable while a command is held: it completes, then nothing more until re-enable.
    wait_valid("c_data48");
    en = 1'b0;
    repeat (3) tick();
    chk("c_held", 64'({cmd_if.cmdValid_out, cmd_if.cmdAddr_out}), 64'({1'b1, f2c_base + 32'd48}));
    exp_q.push_back(mk(1'b0, f2c_base + 32'd48, 64'd0));
    accept_one("c_acc");
    cmd_if.cmdReady_in = 1'b1;
    repeat (5) tick();
    chk("c_idle_valid", 64'(cmd_if.cmdValid_out), 64'd0);
    chk("c_idle_wrptr", 64'(wr_ptr), 64'd0);
    cmd_if.cmdReady_in = 1'b0;
    en = 1'b1;
    exp_q.push_back(mk(1'b1, mtr_base, 64'h0000_0005_0000_0000));
    exp_q.push_back(mk(1'b0, f2c_base, 64'd0));
    accept_one("c_re_metric");
    accept_one("c_re_data");

    // Asynchronous reset while a metric is held, then stall counting with no source data.
    do_reset(1'b1);
    cmd_if.cmdReady_in = 1'b0;
    wait_valid("d_metric_valid");
    #3;
    rstn = 1'b0;
    #1;
    chk("d_async_reset", 64'({cmd_if.cmdValid_out, cmd_if.cmdIsMetric_out, |cmd_if.cmdQwCount_out,
                              |cmd_if.cmdAddr_out, |cmd_if.cmdMetric_out, |wr_ptr, |stall_cnt}), 64'd0);
    @(posedge clk_in);
    #1;
    src = 1'b0;
    do_reset(1'b1);
    cmd_if.cmdReady_in = 1'b0;
    exp_q.push_back(mk(1'b1, mtr_base, {c2f, 32'd0}));
    accept_one("d_metric");
    repeat (20) tick();
    chk("d_stallcnt", 64'(stall_cnt), 64'(exp_stall));
    chk("d_no_data", 64'(cmd_if.cmdValid_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
